// File: rtl/cond_sum_pipe.sv
// Pipelined conditional-sum adder/subtractor: one register stage per merge level,
// a global advance enable for backpressure, and registered result outputs.
module cond_sum_pipe #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [TAG_W-1:0] tag_out
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int MSB    = WIDTH - 1;
  localparam int CTOT   = 2 * WIDTH - 1;

  // Carries of every level live in one flat vector; level k starts at coff(k).
  function automatic int coff(input int k);
    return 2 * WIDTH - 2 * (WIDTH >> k);
  endfunction

  logic                          adv_s;
  logic [LEVELS:0][WIDTH-1:0]    s0_d, s1_d, s0_q, s1_q;
  logic [CTOT-1:0]               c0_d, c1_d, c0_q, c1_q;
  logic [LEVELS:0]               cin_q, xm_q, ym_q, vld_q;
  logic [LEVELS:0][TAG_W-1:0]    tag_q;
  logic [WIDTH-1:0]              y_eff_s;

  logic                          out_valid_q, cout_q, ovf_q;
  logic [WIDTH-1:0]              sum_q;
  logic [TAG_W-1:0]              tag_out_q;
  logic [WIDTH-1:0]              sum_d;
  logic                          cout_d, ovf_d;

  assign adv_s    = ~out_valid_q | out_ready;
  assign in_ready = adv_s;

  assign y_eff_s  = sub ? ~y : y;

  // Per-bit cell pair: result assuming carry-in 0 and assuming carry-in 1.
  assign s0_d[0]          = x ^ y_eff_s;
  assign c0_d[WIDTH-1:0]  = x & y_eff_s;
  assign s1_d[0]          = ~(x ^ y_eff_s);
  assign c1_d[WIDTH-1:0]  = x | y_eff_s;

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int GS = 1 << k;
    localparam int H  = GS / 2;
    localparam int NG = WIDTH >> k;
    localparam int PO = coff(k - 1);
    localparam int CO = coff(k);
    for (genvar j = 0; j < NG; j++) begin : g_grp
      localparam int LO = j * GS;
      localparam int UP = j * GS + H;
      assign s0_d[k][LO +: H] = s0_q[k-1][LO +: H];
      assign s1_d[k][LO +: H] = s1_q[k-1][LO +: H];
      // The lower group's carry-out picks which upper candidate survives.
      assign s0_d[k][UP +: H] = c0_q[PO+2*j] ? s1_q[k-1][UP +: H] : s0_q[k-1][UP +: H];
      assign c0_d[CO+j]       = c0_q[PO+2*j] ? c1_q[PO+2*j+1]     : c0_q[PO+2*j+1];
      assign s1_d[k][UP +: H] = c1_q[PO+2*j] ? s1_q[k-1][UP +: H] : s0_q[k-1][UP +: H];
      assign c1_d[CO+j]       = c1_q[PO+2*j] ? c1_q[PO+2*j+1]     : c0_q[PO+2*j+1];
    end
  end

  assign sum_d  = cin_q[LEVELS] ? s1_q[LEVELS] : s0_q[LEVELS];
  assign cout_d = cin_q[LEVELS] ? c1_q[CTOT-1] : c0_q[CTOT-1];
  assign ovf_d  = (xm_q[LEVELS] == ym_q[LEVELS]) & (sum_d[MSB] != xm_q[LEVELS]);

  // Every stage, sideband and the output register move together on adv.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_q        <= '0;
      s1_q        <= '0;
      c0_q        <= '0;
      c1_q        <= '0;
      cin_q       <= '0;
      xm_q        <= '0;
      ym_q        <= '0;
      vld_q       <= '0;
      tag_q       <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      tag_out_q   <= '0;
    end else if (adv_s) begin
      s0_q        <= s0_d;
      s1_q        <= s1_d;
      c0_q        <= c0_d;
      c1_q        <= c1_d;
      cin_q       <= {cin_q[LEVELS-1:0], cin};
      xm_q        <= {xm_q[LEVELS-1:0], x[MSB]};
      ym_q        <= {ym_q[LEVELS-1:0], y_eff_s[MSB]};
      vld_q       <= {vld_q[LEVELS-1:0], in_valid};
      tag_q       <= {tag_q[LEVELS-1:0], tag_in};
      out_valid_q <= vld_q[LEVELS];
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      tag_out_q   <= tag_q[LEVELS];
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign tag_out   = tag_out_q;

endmodule
